// File: rtl/cmp_lgez_serial.sv
// cmp_lgez_serial: slice-serial unsigned comparator producing a 2-bit code
//   00 = both zero, 11 = equal and nonzero, 01 = X<Y, 10 = X>Y.
// Operands are compared p_WIDTH bits per cycle, most significant slice first.
// Optional feature macro: CMP_LGEZ_SERIAL_EARLY_EXIT_EN
//   defined   -> leave RUN on the first differing slice
//   undefined -> always spend exactly p_SLICES cycles in RUN
module cmp_lgez_serial #(
    parameter int unsigned p_WIDTH  = 3,
    parameter int unsigned p_SLICES = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [p_WIDTH*p_SLICES-1:0]   iv_x,
    input  logic [p_WIDTH*p_SLICES-1:0]   iv_y,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [1:0]                    ov_res,
    output logic                          o_busy
);

    localparam int unsigned OW   = p_WIDTH * p_SLICES;
    localparam int unsigned IDXW = (p_SLICES > 1) ? $clog2(p_SLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(p_SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [OW-1:0]       x_q;
    logic [OW-1:0]       y_q;
    logic [IDXW-1:0]     idx_q;
    logic                nz_q;
    logic [1:0]          res_q;
    logic                ready_q;
    logic                busy_q;
    logic                valid_q;
`ifndef CMP_LGEZ_SERIAL_EARLY_EXIT_EN
    logic [1:0]          diff_q;     // first differing slice code, 00 = none yet
    logic [1:0]          pending;
`endif

    logic [p_WIDTH-1:0]  slice_x;
    logic [p_WIDTH-1:0]  slice_y;
    logic [1:0]          slice_code;
    logic                slice_diff;
    logic                nz_acc;
    logic [1:0]          done_code;
    logic                finish;

    // Compare the current slice and work out the decision for this RUN cycle
    always_comb begin
        slice_x    = x_q[idx_q*p_WIDTH +: p_WIDTH];
        slice_y    = y_q[idx_q*p_WIDTH +: p_WIDTH];
        slice_code = 2'b00;
        if (slice_x > slice_y) begin
            slice_code = 2'b10;
        end else if (slice_x < slice_y) begin
            slice_code = 2'b01;
        end else if (slice_x != '0) begin
            slice_code = 2'b11;
        end
        slice_diff = slice_code[1] ^ slice_code[0];
        nz_acc     = nz_q | (slice_code == 2'b11);
`ifdef CMP_LGEZ_SERIAL_EARLY_EXIT_EN
        done_code  = slice_diff ? slice_code : (nz_acc ? 2'b11 : 2'b00);
        finish     = slice_diff || (idx_q == '0);
`else
        // Only the most significant differing slice decides; later ones are ignored
        pending    = (diff_q != 2'b00) ? diff_q : (slice_diff ? slice_code : 2'b00);
        done_code  = (pending != 2'b00) ? pending : (nz_acc ? 2'b11 : 2'b00);
        finish     = (idx_q == '0);
`endif
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= LAST_IDX;
            nz_q    <= 1'b0;
            res_q   <= 2'b00;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifndef CMP_LGEZ_SERIAL_EARLY_EXIT_EN
            diff_q  <= 2'b00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        x_q     <= iv_x;
                        y_q     <= iv_y;
                        nz_q    <= 1'b0;
                        idx_q   <= LAST_IDX;
`ifndef CMP_LGEZ_SERIAL_EARLY_EXIT_EN
                        diff_q  <= 2'b00;
`endif
                        state_q <= S_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (finish) begin
                        res_q   <= done_code;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        idx_q   <= idx_q - IDXW'(1);
                        nz_q    <= nz_acc;
`ifndef CMP_LGEZ_SERIAL_EARLY_EXIT_EN
                        diff_q  <= pending;
`endif
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign ov_res  = res_q;

endmodule

// File: tb/tb_cmp_lgez_serial.sv
// Testbench for cmp_lgez_serial (p_WIDTH=3, p_SLICES=4): directed vector table,
// backpressure and mid-run reset sequences, exhaustive 6-bit sweep and random ops.
module tb_cmp_lgez_serial;

    localparam int W  = 3;
    localparam int SL = 4;
    localparam int OW = W * SL;

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [OW-1:0] iv_x;
    logic [OW-1:0] iv_y;
    logic          o_valid;
    logic          i_ready;
    logic [1:0]    ov_res;
    logic          o_busy;

    int errors;
    int checks;

    cmp_lgez_serial #(.p_WIDTH(W), .p_SLICES(SL)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .iv_x    (iv_x),
        .iv_y    (iv_y),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .ov_res  (ov_res),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [OW-1:0] x;
        logic [OW-1:0] y;
        logic [1:0]    res;
        int            lat_ee;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference result from whole-operand unsigned arithmetic
    function automatic logic [1:0] ref_res(input logic [OW-1:0] x, input logic [OW-1:0] y);
        if (x == y) return (x == 0) ? 2'b00 : 2'b11;
        return (x < y) ? 2'b01 : 2'b10;
    endfunction

    // Reference latency: position of the first differing slice, or full length
    function automatic int ref_lat(input logic [OW-1:0] x, input logic [OW-1:0] y);
`ifdef CMP_LGEZ_SERIAL_EARLY_EXIT_EN
        int unsigned mask;
        mask = (1 << W) - 1;
        for (int s = SL - 1; s >= 0; s--) begin
            if (((int'(x) >> (s * W)) & mask) != ((int'(y) >> (s * W)) & mask))
                return SL - s;
        end
        return SL;
`else
        return SL;
`endif
    endfunction

    function automatic int table_lat(input int lat_ee);
`ifdef CMP_LGEZ_SERIAL_EARLY_EXIT_EN
        return lat_ee;
`else
        if (lat_ee > 0) return SL;
        return SL;
`endif
    endfunction

    // Issue one operation from IDLE and wait for its result (not released)
    task automatic run_op(input logic [OW-1:0] x, input logic [OW-1:0] y,
                          input logic [1:0] er, input int el, input string tag,
                          input bit full);
        int n;
        iv_x    = x;
        iv_y    = y;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        iv_x    = ~x;
        iv_y    = ~y;
        if (full) begin
            check({tag, "_busy"}, int'(o_busy), 1);
            check({tag, "_ready_run"}, int'(o_ready), 0);
        end
        n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, int'(o_valid), 1);
        check({tag, "_lat"}, n, el);
        check({tag, "_res"}, int'(ov_res), int'(er));
    endtask

    task automatic release_op(input string tag, input bit full);
        i_ready = 1'b1;
        tick();
        check({tag, "_ready_idle"}, int'(o_ready), 1);
        if (full) check({tag, "_valid_idle"}, int'(o_valid), 0);
    endtask

    initial begin
        logic [1:0]    held;
        logic [OW-1:0] rx;
        logic [OW-1:0] ry;
        errors  = 0;
        checks  = 0;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        iv_x    = '0;
        iv_y    = '0;

        vecs[0] = '{x: 12'h000, y: 12'h000, res: 2'b00, lat_ee: 4};
        vecs[1] = '{x: 12'h800, y: 12'h7FF, res: 2'b10, lat_ee: 1};
        vecs[2] = '{x: 12'h001, y: 12'h001, res: 2'b11, lat_ee: 4};
        vecs[3] = '{x: 12'h005, y: 12'h006, res: 2'b01, lat_ee: 4};
        vecs[4] = '{x: 12'hFFF, y: 12'hFFF, res: 2'b11, lat_ee: 4};
        vecs[5] = '{x: 12'h0C0, y: 12'h080, res: 2'b10, lat_ee: 2};
        vecs[6] = '{x: 12'h038, y: 12'h040, res: 2'b01, lat_ee: 2};
        vecs[7] = '{x: 12'h007, y: 12'h00F, res: 2'b01, lat_ee: 3};

        // Reset state
        #2 i_rst = 1'b1;
        #1;
        check("rst_ready", int'(o_ready), 1);
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy",  int'(o_busy), 0);
        check("rst_res",   int'(ov_res), 0);
        tick();
        tick();
        i_rst = 1'b0;

        // Directed table; first entry is accepted on the first edge after reset
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].res, table_lat(vecs[i].lat_ee),
                   $sformatf("vec%0d", i), 1'b1);
            release_op($sformatf("vec%0d", i), 1'b1);
        end

        // Backpressure: hold result for 3 cycles, then release for one edge
        i_ready = 1'b0;
        run_op(12'h800, 12'h7FF, 2'b10, table_lat(1), "bp", 1'b1);
        held = ov_res;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", c), int'(o_valid), 1);
            check($sformatf("bp_hold%0d_res", c), int'(ov_res), int'(held));
            check($sformatf("bp_hold%0d_ready", c), int'(o_ready), 0);
        end
        release_op("bp", 1'b1);

        // Reset pulsed during the second RUN cycle
        iv_x    = 12'h005;
        iv_y    = 12'h006;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        check("mrst_busy_pre", int'(o_busy), 1);
        i_rst = 1'b1;
        #1;
        check("mrst_busy",  int'(o_busy), 0);
        check("mrst_valid", int'(o_valid), 0);
        check("mrst_res",   int'(ov_res), 0);
        check("mrst_ready", int'(o_ready), 1);
        i_rst = 1'b0;
        run_op(12'h000, 12'h000, 2'b00, SL, "mrst_new", 1'b1);
        release_op("mrst_new", 1'b1);

        // Exhaustive low 6 bits
        for (int xa = 0; xa < 64; xa++) begin
            for (int ya = 0; ya < 64; ya++) begin
                rx = OW'(xa);
                ry = OW'(ya);
                run_op(rx, ry, ref_res(rx, ry), ref_lat(rx, ry),
                       $sformatf("ex_%0d_%0d", xa, ya), 1'b0);
                release_op("ex", 1'b0);
            end
        end

        // Random full-width operands, some forced equal or sharing upper bits
        for (int r = 0; r < 300; r++) begin
            rx = OW'($urandom);
            ry = OW'($urandom);
            case ($urandom_range(3))
                0: ry = rx;
                1: ry = {rx[OW-1:W], ry[W-1:0]};
                default: ;
            endcase
            run_op(rx, ry, ref_res(rx, ry), ref_lat(rx, ry),
                   $sformatf("rnd%0d_x%03h_y%03h", r, rx, ry), 1'b1);
            i_ready = 1'b0;
            for (int k = 0; k < int'($urandom_range(2)); k++) tick();
            check($sformatf("rnd%0d_hold", r), int'(ov_res), int'(ref_res(rx, ry)));
            release_op($sformatf("rnd%0d", r), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_lgez_serial.md
CMP_LGEZ_SERIAL -- requirements
Module: cmp_lgez_serial

Interface
REQ-001 Parameter p_WIDTH, default 3: width of one comparison slice in bits; minimum 1.
REQ-002 Parameter p_SLICES, default 4: number of slices per operand; minimum 2.
REQ-003 Operand width SHALL be p_WIDTH*p_SLICES bits, written OW below.
REQ-004 Port i_clk, input, 1 bit: single clock; all state SHALL change on the rising edge.
REQ-005 Port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port i_valid, input, 1 bit: operands on iv_x/iv_y are valid.
REQ-007 Port o_ready, output, 1 bit: block can accept operands.
REQ-008 Port iv_x, input, OW bits: operand X, unsigned.
REQ-009 Port iv_y, input, OW bits: operand Y, unsigned.
REQ-010 Port o_valid, output, 1 bit: result on ov_res is valid.
REQ-011 Port i_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port ov_res, output, 2 bits: result code. 00 = both zero; 11 = equal and nonzero; 01 = X<Y; 10 = X>Y.
REQ-013 Port o_busy, output, 1 bit: comparison in progress (RUN state).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 o_ready SHALL be 1 only in IDLE; o_busy SHALL be 1 only in RUN; o_valid SHALL be 1 only in DONE.
REQ-016 Accept: on an edge with state IDLE and i_valid=1, the block SHALL register iv_x and iv_y, clear the nz flag, set the slice index to p_SLICES-1, and enter RUN.
REQ-017 Operand inputs SHALL be ignored outside the accept edge.
REQ-018 In RUN, each cycle SHALL compare exactly one slice of the registered operands, at bits [idx*p_WIDTH +: p_WIDTH], MSB slice first.
REQ-019 Each slice compare SHALL produce a code with the same encoding as ov_res.
REQ-020 Slice code 01 or 10: the block SHALL latch that code into ov_res and enter DONE, subject to REQ-032.
REQ-021 Slice code 11: the block SHALL set the nz flag, decrement idx, and stay in RUN.
REQ-022 Slice code 00: the block SHALL decrement idx and stay in RUN.
REQ-023 On the idx=0 cycle with slice code 00 or 11, the block SHALL enter DONE with ov_res = 11 if nz (including this slice) is set, else 00.
REQ-024 Latency: if the decision is made in the n-th RUN cycle, o_valid SHALL be 1 starting n edges after the accept edge; 1 <= n <= p_SLICES.
REQ-025 In DONE, ov_res and o_valid SHALL hold while i_ready=0.
REQ-026 On an edge in DONE with i_ready=1, the block SHALL enter IDLE.
REQ-027 After REQ-026, o_ready SHALL be 1 from the following cycle; there is no same-cycle re-accept.
REQ-028 ov_res SHALL keep its last value in IDLE and RUN until overwritten per REQ-020 or REQ-023.
REQ-029 The slice index counter SHALL never wrap below 0; the state SHALL leave RUN on the idx=0 cycle.

Reset
REQ-030 While i_rst=1, asynchronously and at any time including mid-RUN: state IDLE, o_ready=1, o_valid=0, o_busy=0, ov_res=00, idx=p_SLICES-1, nz=0, operand registers 0.
REQ-031 The first accept SHALL be possible on the first rising edge after i_rst deasserts.

Configuration
REQ-032 Macro CMP_LGEZ_SERIAL_EARLY_EXIT_EN controls early exit.
- Defined: REQ-020 applies; the block leaves RUN on the first differing slice.
- Undefined: the first 01/10 slice code is latched internally and later slices do not change it; the block stays in RUN for exactly p_SLICES cycles, giving constant latency p_SLICES.
- The final ov_res SHALL be identical in both builds.

Verification (p_WIDTH=3, p_SLICES=4, OW=12)
REQ-033 X=12'h000, Y=12'h000 accepted -> ov_res=00, o_valid rises 4 edges after accept, in both builds.
REQ-034 X=12'h800, Y=12'h7FF -> ov_res=10; o_valid after 1 edge with the macro defined, after 4 edges without.
REQ-035 X=12'h001, Y=12'h001 -> ov_res=11 after 4 edges; X=12'h005, Y=12'h006 -> ov_res=01 after 4 edges.
REQ-036 Backpressure: i_ready=0 for 3 cycles in DONE -> o_valid=1, ov_res stable, o_ready=0; then i_ready=1 for 1 edge -> IDLE, o_ready=1 on the next cycle.
REQ-037 i_rst pulsed during the 2nd RUN cycle of X=12'h005, Y=12'h006 -> immediately o_busy=0, o_valid=0, ov_res=00, o_ready=1; a new accept of X=12'h000, Y=12'h000 then completes with ov_res=00.
REQ-038 Exhaustive loop over all X,Y in 0..63, upper bits 0 -> ov_res matches the unsigned compare, checked against a reference model.
